// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling datapath: default geometry and the
// pooling FSM state encoding used by mac_pool_stage.
package cnn_pkg;

    localparam int ROW_W_DEF = 8;
    localparam int COL_H_DEF = 8;
    localparam int ACT_W_DEF = 32;
    localparam int MAC_W     = 64;

    // FILL collects the even row into the line buffer, POOL emits 2x2 maxima.
    typedef enum logic {
        FILL = 1'b0,
        POOL = 1'b1
    } pool_state_e;

endpackage : cnn_pkg

// File: rtl/pool_linebuf.sv
// Half-row line buffer: one synchronous write port, one combinational read port.
// Holds the horizontal maxima of the even row until the odd row consumes them.
module pool_linebuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset: every entry is rewritten during FILL before POOL reads it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : pool_linebuf

// File: rtl/mac_pool_stage.sv
// ReLU + saturate + 2x2 max-pool stage for a row-major stream of 64-bit MAC
// results, with a one-entry registered output and valid/ready flow control.
module mac_pool_stage
    import cnn_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_H = COL_H_DEF,
    parameter int ACT_W = ACT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACT_W-1:0] out_data,
    output logic             out_last
);

    localparam int CW       = $clog2(ROW_W);
    localparam int RW       = $clog2(COL_H);
    localparam int LB_DEPTH = ROW_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    function automatic logic [ACT_W-1:0] umax(input logic [ACT_W-1:0] a,
                                              input logic [ACT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    pool_state_e      state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [ACT_W-1:0] hold_q, hold_d;
    logic [ACT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic [ACT_W-1:0] act;
    logic [ACT_W-1:0] hmax;
    logic [ACT_W-1:0] lb_rdata;
    logic [LB_AW-1:0] lb_addr;
    logic             lb_we;
    logic             pool_fire;

    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = (col_q == CW'(ROW_W - 1));
    assign row_last = (row_q == RW'(COL_H - 1));
    assign lb_addr  = LB_AW'(col_q >> 1);
    assign hmax     = umax(hold_q, act);

    // Negative results clamp to zero; anything wider than ACT_W saturates.
    always_comb begin
        act = in_data[ACT_W-1:0];
        if (in_data[MAC_W-1]) begin
            act = '0;
        end else if ((in_data >> ACT_W) != '0) begin
            act = '1;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (accept && !col_q[0]) begin
            hold_d = act;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && col_last) begin
            case (state_q)
                FILL:    state_d = POOL;
                POOL:    state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // Odd columns complete a horizontal pair; the state decides where it goes.
    always_comb begin
        lb_we     = 1'b0;
        pool_fire = 1'b0;
        if (accept && col_q[0]) begin
            if (state_q == FILL) begin
                lb_we = 1'b1;
            end else begin
                pool_fire = 1'b1;
            end
        end
    end

    pool_linebuf #(
        .DEPTH (LB_DEPTH),
        .WIDTH (ACT_W),
        .AW    (LB_AW)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (hmax),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    // A new pooled value may replace a consumed one in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (pool_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = umax(lb_rdata, hmax);
            out_last_d  = row_last && col_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule : mac_pool_stage

// File: tb/tb_mac_pool_stage.sv
// Self-checking bench for mac_pool_stage (4x2 frames): directed frames plus
// randomized traffic compared against a frame-array 2x2 max-pool model.
module tb_mac_pool_stage;

    localparam int ROW_W = 4;
    localparam int COL_H = 2;
    localparam int ACT_W = 32;
    localparam int FRAME = ROW_W * COL_H;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACT_W-1:0] out_data;
    logic             out_last;

    always #5 clk = ~clk;

    mac_pool_stage #(
        .ROW_W (ROW_W),
        .COL_H (COL_H),
        .ACT_W (ACT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [ACT_W-1:0] data;
        logic             last;
    } exp_t;

    int               checkCount = 0;
    int               failCount  = 0;
    int               stallCount = 0;
    bit               randMode   = 1'b0;
    int               sampleIdx  = 0;
    logic [ACT_W-1:0] frameAct [COL_H][ROW_W];
    exp_t             expQ[$];
    exp_t             monExp;
    logic [ACT_W-1:0] obsData[$];
    logic             obsLast[$];
    logic [63:0]      frameA [FRAME];
    logic [63:0]      frameB [FRAME];
    logic [63:0]      frameNeg [FRAME];
    logic [63:0]      frameSat [FRAME];
    logic [63:0]      frameRnd [FRAME];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [ACT_W-1:0] reluSat(input logic [63:0] v);
        if ($signed(v) < 0) return '0;
        if (v > 64'h0000_0000_FFFF_FFFF) return '1;
        return v[ACT_W-1:0];
    endfunction

    // Model: store the frame as a 2D array and pool each 2x2 window once complete.
    task automatic modelAccept(input logic [63:0] v);
        int r;
        int c;
        logic [ACT_W-1:0] m;
        r = sampleIdx / ROW_W;
        c = sampleIdx % ROW_W;
        frameAct[r][c] = reluSat(v);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = frameAct[r-1][c-1];
            if (frameAct[r-1][c] > m) m = frameAct[r-1][c];
            if (frameAct[r][c-1] > m) m = frameAct[r][c-1];
            if (frameAct[r][c] > m)   m = frameAct[r][c];
            expQ.push_back('{data: m, last: (sampleIdx == FRAME - 1)});
        end
        sampleIdx = (sampleIdx + 1) % FRAME;
    endtask

    task automatic modelReset();
        sampleIdx = 0;
        expQ.delete();
    endtask

    // Outputs are taken when valid and ready are both high at the coming edge.
    always @(negedge clk) begin
        #2;
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 64'(out_data), 64'hDEAD);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("out_data", 64'(out_data), 64'(monExp.data));
                checkOutput("out_last", 64'(out_last), 64'(monExp.last));
            end
            obsData.push_back(out_data);
            obsLast.push_back(out_last);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [63:0] v);
        int waitCycles;
        waitCycles = 0;
        if (randMode) out_ready = ($urandom_range(0, 3) != 0);
        if (randMode && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            #1;
            if (in_ready) begin
                modelAccept(v);
                @(negedge clk);
                break;
            end
            stallCount++;
            waitCycles++;
            if (waitCycles > 50) begin
                checkOutput("accept_timeout", 64'(in_ready), 64'd1);
                @(negedge clk);
                break;
            end
            @(negedge clk);
            if (randMode) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [63:0] f [FRAME]);
        for (int i = 0; i < FRAME; i++) applyStimulus(f[i]);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((expQ.size() != 0 || out_valid) && n < 40);
        checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic clearObs();
        obsData.delete();
        obsLast.delete();
    endtask

    task automatic checkObs(input string tag, input int idx,
                            input logic [ACT_W-1:0] d, input logic l);
        if (idx < obsData.size()) begin
            checkOutput({tag, "_data"}, 64'(obsData[idx]), 64'(d));
            checkOutput({tag, "_last"}, 64'(obsLast[idx]), 64'(l));
        end else begin
            checkOutput({tag, "_count"}, 64'(obsData.size()), 64'(idx + 1));
        end
    endtask

    function automatic logic [63:0] randMac();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 4) return 64'($signed($urandom_range(0, 2000)) - 1000);
        if (sel < 6) return {32'h0, $urandom()};
        if (sel < 8) return {1'b1, 31'($urandom()), $urandom()};
        return {1'b0, 31'($urandom_range(0, 3)), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frameA   = '{64'd1, 64'd5, -64'sd3, 64'd2, 64'd4, 64'd0, 64'd7, -64'sd9};
        frameB   = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60, 64'd70, 64'd80};
        frameNeg = '{default: 64'hFFFF_FFFF_FFFF_FFFF};
        frameSat = '{64'h0000_0001_0000_0000, 64'd3, 64'd1, 64'd2,
                     64'd0, -64'sd5, 64'd9, 64'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_last", 64'(out_last), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        $display("[TB] basic frame");
        clearObs();
        sendFrame(frameA);
        waitDrain();
        checkObs("basic0", 0, 32'd5, 1'b0);
        checkObs("basic1", 1, 32'd7, 1'b1);

        $display("[TB] all-negative frame");
        clearObs();
        sendFrame(frameNeg);
        waitDrain();
        checkObs("neg0", 0, 32'd0, 1'b0);
        checkObs("neg1", 1, 32'd0, 1'b1);

        $display("[TB] saturation frame");
        clearObs();
        sendFrame(frameSat);
        waitDrain();
        checkObs("sat0", 0, 32'hFFFF_FFFF, 1'b0);
        checkObs("sat1", 1, 32'd9, 1'b1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 3; i++) applyStimulus(frameB[i]);
        #3 rst = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_out_data", 64'(out_data), 64'd0);
        checkOutput("midreset_out_last", 64'(out_last), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        clearObs();
        sendFrame(frameA);
        waitDrain();
        checkObs("fresh0", 0, 32'd5, 1'b0);
        checkObs("fresh1", 1, 32'd7, 1'b1);

        $display("[TB] output backpressure");
        clearObs();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(frameA[i]);
        in_valid = 1'b1;
        in_data  = frameA[6];
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_out_data", 64'(out_data), 64'd5);
            checkOutput("stall_out_last", 64'(out_last), 64'd0);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(frameA[6]);
        applyStimulus(frameA[7]);
        waitDrain();
        checkObs("stall0", 0, 32'd5, 1'b0);
        checkObs("stall1", 1, 32'd7, 1'b1);

        $display("[TB] back-to-back frames");
        clearObs();
        stallCount = 0;
        out_ready  = 1'b1;
        sendFrame(frameA);
        sendFrame(frameB);
        checkOutput("b2b_stalls", 64'(stallCount), 64'd0);
        waitDrain();
        checkOutput("b2b_count", 64'(obsData.size()), 64'd4);
        checkObs("b2b0", 0, 32'd5, 1'b0);
        checkObs("b2b1", 1, 32'd7, 1'b1);
        checkObs("b2b2", 2, 32'd60, 1'b0);
        checkObs("b2b3", 3, 32'd80, 1'b1);

        $display("[TB] randomized traffic");
        randMode = 1'b1;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < FRAME; i++) frameRnd[i] = randMac();
            sendFrame(frameRnd);
        end
        randMode = 1'b0;
        waitDrain();
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_mac_pool_stage
